dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, default 32: requester and memory address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 m0_req  in  1  master 0 access request, held until m0_ack.
REQ-006 m0_we  in  1  master 0 write (1) / read (0); stable while m0_req.
REQ-007 m0_addr  in  AW  master 0 byte address; stable while m0_req.
REQ-008 m0_wdata  in  DW  master 0 write data; stable while m0_req.
REQ-009 m0_ack  out  1  one-cycle completion pulse to master 0.
REQ-010 m0_rdata  out  DW  master 0 registered read data, valid with m0_ack.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same widths, directions and meanings as the m0 ports, for master 1.
REQ-012 dm_addr  out  AW  word index to data memory.
REQ-013 dm_din  out  DW  write data to data memory.
REQ-014 dm_MemWrite  out  1  data memory write enable.
REQ-015 dm_MemRead  out  1  data memory read strobe.
REQ-016 dm_dout  in  DW  combinational read data from data memory.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; reset state IDLE.
REQ-018 IDLE: if any req is high at the posedge, the arbiter latches the winner index (sel) and goes to ACCESS; otherwise it stays in IDLE.
REQ-019 Arbitration is 2-way round-robin: with one requester, that requester wins; with both, the master not in last_grant wins; last_grant updates to the winner on the IDLE->ACCESS edge.
REQ-020 last_grant resets to 1, so master 0 wins the first contested arbitration.
REQ-021 ACCESS lasts exactly one cycle:
- dm_addr = {zero-extend, addr_sel[11:2]}
- dm_din = wdata_sel
- dm_MemWrite = we_sel
- dm_MemRead = ~we_sel
The memory write commits on the ACCESS->RESP edge.
REQ-022 On the ACCESS->RESP edge, dm_dout is registered into rdata of the selected master for reads; on writes, rdata keeps its prior value.
REQ-023 RESP lasts one cycle: ack of sel is high, the other ack is low; next state is IDLE.
REQ-024 Outside ACCESS: dm_MemWrite=0, dm_MemRead=0, dm_addr=0, dm_din=0.
REQ-025 Latency: req sampled at edge t -> access cycle t..t+1 -> ack high during cycle t+2; minimum issue interval per master is 3 cycles.
REQ-026 A req still high in IDLE after its ack is a new request and is arbitrated normally; under continuous contention, grants strictly alternate.
REQ-027 A master dropping req before ack is a protocol violation; the access in flight still completes and acks.
REQ-028 Address bits [1:0] and [AW-1:12] are ignored.
REQ-029 At most one ack is high in any cycle; an ack is never high outside RESP.

Reset
REQ-030 Assertion of reset immediately (asynchronously) forces:
- state=IDLE, last_grant=1, sel=0
- m0_ack=m1_ack=0, m0_rdata=m1_rdata=0
- dm_MemWrite=dm_MemRead=0, dm_addr=dm_din=0
REQ-031 Reset asserted during ACCESS removes dm_MemWrite before the next edge, so no write commits; the interrupted request is not acked.
REQ-032 After reset deasserts, the first arbitration happens at the first posedge with reset high.

Structure
REQ-033 Shared package dm_arb_pkg holds the state enum (IDLE/ACCESS/RESP), the state encoding width, and the word-index slice constants (12, 2).
REQ-034 One sub-module, rr_arb2: inputs req[1:0] and last_grant; outputs valid and winner; purely combinational; instantiated once.

Verification
REQ-035 Single write then read: m0 writes 0xDEADBEEF to addr 0x10 -> dm_MemWrite=1 with dm_addr=4 for one cycle; a later m0 read of 0x10 gives m0_rdata=0xDEADBEEF with the m0_ack pulse, 2 cycles after the req edge.
REQ-036 Simultaneous first request: m0 and m1 both read right after reset -> m0 acked first, m1 acked 3 cycles later; m1_ack and m0_ack never overlap.
REQ-037 Continuous contention: both reqs held high for 12 cycles -> ack order m0,m1,m0,m1, one ack every 3 cycles.
REQ-038 Reset mid-access: reset low during ACCESS of an m1 write of 0x55 to addr 0x20 -> dm_MemWrite drops immediately, memory word 8 is unchanged, m1_ack never pulses, state is IDLE.
REQ-039 Read isolation: m1 reads word 3 (=0x1234) while m0 is idle -> m1_rdata=0x1234, m0_rdata holds its previous value, and dm_MemRead is high for exactly one cycle.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dm_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Byte address bits [WIDX_TOP-1:WIDX_LSB] form the memory word index.
    localparam int WIDX_TOP = 12;
    localparam int WIDX_LSB = 2;
    localparam int WIDX_W   = WIDX_TOP - WIDX_LSB;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes
// to the master that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = req[0] | req[1];
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates two request/ack masters onto one single-port data memory:
// IDLE (arbitrate) -> ACCESS (drive memory) -> RESP (ack the winner).
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_MemWrite,
    output logic          dm_MemRead,
    input  logic [DW-1:0] dm_dout
);

    state_t        state;
    state_t        next_state;
    logic          sel;
    logic          last_grant;
    logic          arb_valid;
    logic          arb_winner;
    logic          we_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;
    logic          unused_addr_bits;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign we_sel    = sel ? m1_we    : m0_we;
    assign addr_sel  = sel ? m1_addr  : m0_addr;
    assign wdata_sel = sel ? m1_wdata : m0_wdata;

    // Byte-offset and high address bits do not reach the memory.
    assign unused_addr_bits = ^{addr_sel[WIDX_LSB-1:0], addr_sel[AW-1:WIDX_TOP]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arb_valid) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Winner is captured only when leaving IDLE, so it stays fixed for the
    // whole access even if the masters change their requests meanwhile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel        <= 1'b0;
            last_grant <= 1'b1;
        end else if (state == IDLE && arb_valid) begin
            sel        <= arb_winner;
            last_grant <= arb_winner;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (state == ACCESS && !we_sel) begin
            if (sel) begin
                m1_rdata <= dm_dout;
            end else begin
                m0_rdata <= dm_dout;
            end
        end
    end

    // Memory strobes decode from state alone, so an asynchronous reset in
    // ACCESS removes the write enable before the next edge.
    always_comb begin
        dm_addr     = '0;
        dm_din      = '0;
        dm_MemWrite = 1'b0;
        dm_MemRead  = 1'b0;
        m0_ack      = 1'b0;
        m1_ack      = 1'b0;
        case (state)
            ACCESS: begin
                dm_addr     = {{(AW-WIDX_W){1'b0}}, addr_sel[WIDX_TOP-1:WIDX_LSB]};
                dm_din      = wdata_sel;
                dm_MemWrite = we_sel;
                dm_MemRead  = ~we_sel;
            end
            RESP: begin
                m0_ack = ~sel;
                m1_ack = sel;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural data memory attached.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic          dm_MemWrite, dm_MemRead;
    logic [DW-1:0] dm_dout;

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_MemWrite(dm_MemWrite),
        .dm_MemRead(dm_MemRead), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    assign dm_dout = mem[dm_addr[9:0]];
    always @(posedge clk) if (dm_MemWrite) mem[dm_addr[9:0]] <= dm_din;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            m;
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] sh_rd [2];
    logic [DW-1:0] cur_rd [2];
    bit            auto_drop = 1'b1;
    int            total = 0;
    int            bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit m, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int lat);
        exp_t e;
        int   w;
        w    = int'(addr[11:2]);
        e.m  = m;
        e.at = cyc + lat;
        if (we) begin
            ref_mem[w] = wd;
            e.data     = sh_rd[m];
        end else begin
            e.data   = ref_mem[w];
            sh_rd[m] = ref_mem[w];
        end
        sb.push_back(e);
    endtask

    task automatic drive(input bit m, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        if (m) begin
            m1_we = we; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        end
    endtask

    task automatic issue(input bit m, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int lat);
        push_exp(m, we, addr, wd, lat);
        drive(m, we, addr, wd);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check_eq("drain", sb.size(), 0);
        step();
    endtask

    // Ack monitor: pops the scoreboard on every ack seen away from the edge.
    always @(negedge clk) begin
        if (m0_ack || m1_ack) begin
            check_eq("ack_onehot", m0_ack & m1_ack, 1'b0);
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", {m1_ack, m0_ack}, 2'b00);
            end else begin
                mon_e = sb.pop_front();
                check_eq("ack_master", m1_ack, mon_e.m);
                check_eq("ack_cycle", cyc, mon_e.at);
                check_eq("rdata", mon_e.m ? m1_rdata : m0_rdata, mon_e.data);
                cur_rd[mon_e.m] = mon_e.data;
                check_eq("rdata_other", mon_e.m ? m0_rdata : m1_rdata, cur_rd[!mon_e.m]);
            end
            if (auto_drop) begin
                if (m1_ack) m1_req = 1'b0;
                if (m0_ack) m0_req = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'hC0DE_0000 + i;
            ref_mem[i] = 32'hC0DE_0000 + i;
        end
        mem[3] = 32'h0000_1234;
        ref_mem[3] = 32'h0000_1234;
        sh_rd[0] = '0; sh_rd[1] = '0; cur_rd[0] = '0; cur_rd[1] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_state", dut.state, IDLE);
        check_eq("rst_acks", {m1_ack, m0_ack}, 2'b00);
        check_eq("rst_m0_rdata", m0_rdata, 32'h0);
        check_eq("rst_m1_rdata", m1_rdata, 32'h0);
        check_eq("rst_strobes", {dm_MemWrite, dm_MemRead}, 2'b00);
        check_eq("rst_dm_addr", dm_addr, 32'h0);
        check_eq("rst_dm_din", dm_din, 32'h0);

        // Simultaneous first request: m0 wins, m1 three cycles later
        step();
        reset = 1'b1;
        issue(1'b0, 1'b0, 32'h0000_0024, '0, 2);
        issue(1'b1, 1'b0, 32'h0000_0040, '0, 5);
        wait_drain();

        // Continuous contention for 12 cycles: strict alternation
        auto_drop = 1'b0;
        push_exp(1'b0, 1'b0, 32'h0000_0104, '0, 2);
        push_exp(1'b1, 1'b0, 32'h0000_0208, '0, 5);
        push_exp(1'b0, 1'b0, 32'h0000_0104, '0, 8);
        push_exp(1'b1, 1'b0, 32'h0000_0208, '0, 11);
        drive(1'b0, 1'b0, 32'h0000_0104, '0);
        drive(1'b1, 1'b0, 32'h0000_0208, '0);
        repeat (12) @(posedge clk);
        #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        auto_drop = 1'b1;
        repeat (4) step();
        check_eq("contention_drain", sb.size(), 0);

        // Write then read back through m0
        issue(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2);
        step();
        check_eq("wr_memwrite", dm_MemWrite, 1'b1);
        check_eq("wr_memread", dm_MemRead, 1'b0);
        check_eq("wr_dm_addr", dm_addr, 32'h4);
        check_eq("wr_dm_din", dm_din, 32'hDEAD_BEEF);
        step();
        check_eq("wr_memwrite_off", dm_MemWrite, 1'b0);
        check_eq("wr_dm_addr_off", dm_addr, 32'h0);
        wait_drain();
        check_eq("wr_mem4", mem[4], 32'hDEAD_BEEF);
        issue(1'b0, 1'b0, 32'h0000_0010, '0, 2);
        wait_drain();

        // Read isolation: m1 reads word 3 with junk in the ignored bits
        issue(1'b1, 1'b0, 32'hFFFF_F00E, '0, 2);
        step();
        check_eq("iso_memread", dm_MemRead, 1'b1);
        check_eq("iso_dm_addr", dm_addr, 32'h3);
        step();
        check_eq("iso_memread_off", dm_MemRead, 1'b0);
        wait_drain();
        check_eq("iso_m1_rdata", m1_rdata, 32'h0000_1234);
        check_eq("iso_m0_rdata", m0_rdata, 32'hDEAD_BEEF);

        // Reset during an m1 write access
        drive(1'b1, 1'b1, 32'h0000_0020, 32'h55);
        step();
        check_eq("mid_in_access", dm_MemWrite, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("mid_memwrite", dm_MemWrite, 1'b0);
        check_eq("mid_state", dut.state, IDLE);
        check_eq("mid_m1_rdata", m1_rdata, 32'h0);
        check_eq("mid_m0_rdata", m0_rdata, 32'h0);
        m1_req = 1'b0;
        sh_rd[0] = '0; sh_rd[1] = '0; cur_rd[0] = '0; cur_rd[1] = '0;
        repeat (3) step();
        check_eq("mid_mem8", mem[8], ref_mem[8]);
        check_eq("mid_no_ack", sb.size(), 0);

        // First arbitration after reset release, contested: m0 first again
        reset = 1'b1;
        issue(1'b0, 1'b0, 32'h0000_0030, '0, 2);
        issue(1'b1, 1'b0, 32'h0000_0034, '0, 5);
        wait_drain();
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
